// File: rtl/dtc_arb_pkg.sv
// dtc_arb_pkg: shared types and helpers for the shared decision-tree
// classifier arbiter.
//   arb_state_t   - arbiter FSM state (IDLE, EVAL, RESP)
//   DEF_FEAT_W    - default feature vector width
//   DEF_CLASS_W   - default class code width
//   ID_W(n)       - requester index width, $clog2 with a floor of 1
package dtc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int DEF_FEAT_W  = 12;
  localparam int DEF_CLASS_W = 3;

  function automatic int ID_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dtc_rr_pick.sv
// dtc_rr_pick: combinational round-robin picker.
//   req  [N_REQ]  - request vector
//   ptr  [IW]     - index of the last winner; search starts at ptr+1
//   any           - at least one request present
//   gnt  [N_REQ]  - one-hot grant (zero when no request)
//   idx  [IW]     - index of the granted requester
module dtc_rr_pick
  import dtc_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = ID_W(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] ci;

  // Walk ptr+1 .. ptr+N_REQ (mod N_REQ); the last candidate is ptr itself,
  // so a lone requester that just won can win again.
  always_comb begin
    any = 1'b0;
    gnt = '0;
    idx = '0;
    ci  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      ci = IW'((int'(ptr) + k) % N_REQ);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/dtc_share_arbiter.sv
// dtc_share_arbiter: time-multiplexes one external combinational
// decision-tree classifier among N_REQ requesters.
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - per-requester handshake (ready one-hot or zero)
//   req_feat              - flattened vectors, requester i at [i*FEAT_W +: FEAT_W]
//   dtc_inp / dtc_outp    - registered classifier input / its combinational result
//   rsp_valid/rsp_ready   - response handshake; rsp_class, rsp_id payload
//   stats_clr, stats_cnt  - per-class saturating counters, class k at
//                           [k*CNT_W +: CNT_W]
// Build option: define DTC_ARB_STATS_EN to build the counters; otherwise
// stats_cnt is tied to zero and stats_clr is ignored.
module dtc_share_arbiter
  import dtc_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FEAT_W  = DEF_FEAT_W,
  parameter int CLASS_W = DEF_CLASS_W,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*FEAT_W-1:0]       req_feat,
  output logic [FEAT_W-1:0]             dtc_inp,
  input  logic [CLASS_W-1:0]            dtc_outp,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [CLASS_W-1:0]            rsp_class,
  output logic [ID_W(N_REQ)-1:0]        rsp_id,
  input  logic                          stats_clr,
  output logic [(2**CLASS_W)*CNT_W-1:0] stats_cnt
);

  localparam int IW   = ID_W(N_REQ);
  localparam int NCLS = 2**CLASS_W;

  arb_state_t                    state;
  logic [IW-1:0]                 ptr;
  logic [IW-1:0]                 id_q;
  logic [FEAT_W-1:0]             feat_q;
  logic [CLASS_W-1:0]            class_q;
  logic [N_REQ-1:0][FEAT_W-1:0]  feat_arr;

  logic                          any;
  logic [N_REQ-1:0]              gnt;
  logic [IW-1:0]                 gidx;
  logic                          grant;

  assign feat_arr = req_feat;

  dtc_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (any),
    .gnt (gnt),
    .idx (gidx)
  );

  // A grant is possible from IDLE, or from RESP in the cycle the response
  // is accepted. rst_n gates it so req_ready stays low while in reset.
  assign grant = rst_n && any &&
                 ((state == IDLE) || ((state == RESP) && rsp_ready));

  assign req_ready = grant ? gnt : '0;
  assign dtc_inp   = feat_q;
  assign rsp_valid = (state == RESP);
  assign rsp_class = class_q;
  assign rsp_id    = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= IW'(N_REQ - 1);
      id_q    <= '0;
      feat_q  <= '0;
      class_q <= '0;
    end else begin
      if (grant) begin
        feat_q <= feat_arr[gidx];
        id_q   <= gidx;
        ptr    <= gidx;
      end
      case (state)
        IDLE: if (grant) state <= EVAL;
        EVAL: begin
          class_q <= dtc_outp;
          state   <= RESP;
        end
        RESP: if (rsp_ready) state <= grant ? EVAL : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DTC_ARB_STATS_EN
  logic                         hs;
  logic [NCLS-1:0][CNT_W-1:0]   cnt;

  assign hs        = rsp_valid && rsp_ready;
  assign stats_cnt = cnt;

  // Clear wins over a coincident increment; all-ones holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (stats_clr)
      cnt <= '0;
    else if (hs && (cnt[class_q] != '1))
      cnt[class_q] <= cnt[class_q] + CNT_W'(1);
  end
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign stats_cnt        = '0;
`endif

endmodule

// File: tb/tb_dtc_share_arbiter.sv
// Bench for dtc_share_arbiter: table-driven single-grant vectors plus
// hand-written sequences (latency, backpressure, reset during EVAL,
// fairness, counters). Responses are checked through an expected queue.
module tb_dtc_share_arbiter;
  import dtc_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int FEAT_W  = 12;
  localparam int CLASS_W = 3;
  localparam int CNT_W   = 4;
  localparam int IW      = 2;
  localparam int NCLS    = 8;
`ifdef DTC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                      clk;
  logic                      rst_n;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*FEAT_W-1:0]   req_feat;
  logic [FEAT_W-1:0]         dtc_inp;
  logic [CLASS_W-1:0]        dtc_outp;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [CLASS_W-1:0]        rsp_class;
  logic [IW-1:0]             rsp_id;
  logic                      stats_clr;
  logic [NCLS*CNT_W-1:0]     stats_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classifier stub.
  assign dtc_outp = dtc_inp[2:0];

  dtc_share_arbiter #(
    .N_REQ(N_REQ), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_feat(req_feat),
    .dtc_inp(dtc_inp), .dtc_outp(dtc_outp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_class(rsp_class), .rsp_id(rsp_id),
    .stats_clr(stats_clr), .stats_cnt(stats_cnt)
  );

  typedef struct packed {
    logic [IW-1:0]      id;
    logic [CLASS_W-1:0] cls;
  } exp_t;

  typedef struct {
    logic [N_REQ-1:0] mask;
    int               gid;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic set_feat(input int i, input logic [FEAT_W-1:0] f);
    req_feat[i*FEAT_W +: FEAT_W] = f;
  endtask

  function automatic logic [FEAT_W-1:0] featv(input int v, input int i);
    return FEAT_W'(12'h100 * (v + 1) + 12'h010 * i + ((v * 3 + i) % 8));
  endfunction

  // Pops one expected result on every response handshake.
  task automatic mon();
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_rsp_id", 64'(rsp_id), 64'(e.id));
        chk("sb_rsp_class", 64'(rsp_class), 64'(e.cls));
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N_REQ-1:0] eg;
    logic [NCLS*CNT_W-1:0] ecnt;
    int  grants;
    bit  done;

    rst_n = 1'b0; req_valid = '0; req_feat = '0; rsp_ready = 1'b1; stats_clr = 1'b0;
    tbl[0] = '{4'b1111, 3}; tbl[1] = '{4'b1111, 0};
    tbl[2] = '{4'b0001, 0}; tbl[3] = '{4'b1010, 1};
    tbl[4] = '{4'b1010, 3}; tbl[5] = '{4'b0110, 1};
    tbl[6] = '{4'b0101, 2}; tbl[7] = '{4'b1000, 3};

    // Reset state
    half();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_dtc_inp", 64'(dtc_inp), 64'(0));
    chk("rst_rsp_class", 64'(rsp_class), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_stats", 64'(stats_cnt), 64'(0));
    nxt();
    rst_n = 1'b1;

    // Single request, latency c0 grant / c1 eval / c2 response
    req_valid = 4'b0100; set_feat(2, 12'h005);
    half();
    chk("single_grant", 64'(req_ready), 64'(4'b0100));
    sb.push_back('{id: 2'd2, cls: 3'd5});
    nxt();
    req_valid = '0;
    half();
    chk("single_dtc_inp", 64'(dtc_inp), 64'(12'h005));
    chk("single_no_rsp_c1", 64'(rsp_valid), 64'(0));
    nxt();
    half();
    chk("single_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("single_rsp_class", 64'(rsp_class), 64'(3'b101));
    chk("single_rsp_id", 64'(rsp_id), 64'(2));
    nxt();

    // Table: masks with hand-derived round-robin winners (ptr starts at 2)
    for (int v = 0; v < 8; v++) begin
      req_valid = tbl[v].mask;
      for (int i = 0; i < N_REQ; i++) set_feat(i, featv(v, i));
      half();
      eg = '0;
      eg[tbl[v].gid] = 1'b1;
      chk("tbl_grant", 64'(req_ready), 64'(eg));
      sb.push_back('{id: IW'(tbl[v].gid), cls: CLASS_W'(featv(v, tbl[v].gid))});
      nxt();
      req_valid = '0;
      half();
      chk("tbl_dtc_inp", 64'(dtc_inp), 64'(featv(v, tbl[v].gid)));
      chk("tbl_eval_ready", 64'(req_ready), 64'(0));
      nxt();
      half();
      chk("tbl_rsp_valid", 64'(rsp_valid), 64'(1));
      nxt();
    end

    // Backpressure: hold the response 5 cycles, next grant on acceptance
    req_valid = 4'b0011; set_feat(0, 12'h0A1); set_feat(1, 12'h0B6); rsp_ready = 1'b0;
    half();
    chk("bp_grant", 64'(req_ready), 64'(4'b0001));
    sb.push_back('{id: 2'd0, cls: 3'd1});
    nxt();
    half();
    chk("bp_eval_ready", 64'(req_ready), 64'(0));
    nxt();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      half();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_class", 64'(rsp_class), 64'(1));
      chk("bp_rsp_id", 64'(rsp_id), 64'(0));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      nxt();
    end
    rsp_ready = 1'b1;
    half();
    chk("bp_next_grant", 64'(req_ready), 64'(4'b0010));
    sb.push_back('{id: 2'd1, cls: 3'd6});
    nxt();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin half(); nxt(); end

    // Reset during EVAL of requester 3
    req_valid = 4'b1000; set_feat(3, 12'h3F7);
    half();
    chk("r3_grant", 64'(req_ready), 64'(4'b1000));
    nxt();
    req_valid = 4'b1111;
    for (int i = 0; i < N_REQ; i++) set_feat(i, FEAT_W'(12'h0C0 + i + 1));
    chk("r3_dtc_inp", 64'(dtc_inp), 64'(12'h3F7));
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_req_ready", 64'(req_ready), 64'(0));
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rstmid_dtc_inp", 64'(dtc_inp), 64'(0));
    chk("rstmid_rsp_class", 64'(rsp_class), 64'(0));
    chk("rstmid_rsp_id", 64'(rsp_id), 64'(0));
    half();
    nxt();
    rst_n = 1'b1;

    // Fairness straight out of reset: 0,1,2,3,0,1, one grant per 2 cycles
    for (int k = 0; k < 12; k++) begin
      half();
      if (k == 0) chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
      eg = '0;
      if (k % 2 == 0) eg[(k / 2) % 4] = 1'b1;
      chk("fair_grant", 64'(req_ready), 64'(eg));
      if (k % 2 == 0)
        sb.push_back('{id: IW'((k / 2) % 4), cls: CLASS_W'((k / 2) % 4 + 1)});
      nxt();
    end
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin half(); nxt(); end

    // Counters: clear, then 20 class-5 responses
    stats_clr = 1'b1; nxt(); stats_clr = 1'b0;
    half();
    chk("stats_after_clr", 64'(stats_cnt), 64'(0));
    nxt();
    grants = 0;
    set_feat(0, 12'h005);
    for (int k = 0; k < 60; k++) begin
      req_valid = (grants < 20) ? 4'b0001 : 4'b0000;
      half();
      if (req_ready[0]) begin
        sb.push_back('{id: 2'd0, cls: 3'd5});
        grants++;
      end
      nxt();
    end
    chk("stats_grants", 64'(grants), 64'(20));
    ecnt = '0;
    if (STATS) ecnt[5*CNT_W +: CNT_W] = 4'hF;
    half();
    chk("stats_saturate", 64'(stats_cnt), 64'(ecnt));
    nxt();

    // Clear coincident with a class-5 handshake
    req_valid = 4'b0001; done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      if (rsp_valid) begin stats_clr = 1'b1; done = 1'b1; end
      half();
      if (req_ready[0]) sb.push_back('{id: 2'd0, cls: 3'd5});
      nxt();
    end
    chk("clr_hs_seen", 64'(done), 64'(1));
    stats_clr = 1'b0; req_valid = '0;
    half();
    chk("stats_clr_hs", 64'(stats_cnt), 64'(0));
    nxt();
    for (int k = 0; k < 3; k++) begin half(); nxt(); end
    ecnt = '0;
    if (STATS) ecnt[5*CNT_W +: CNT_W] = 4'h1;
    half();
    chk("stats_after_resume", 64'(stats_cnt), 64'(ecnt));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
